// File: rtl/data_mem_responder_if.sv
// Processor data-memory bus between the CPU FSM (master) and the memory responder (slave).
interface data_mem_responder_if;
  logic       MemRead;
  logic       wren;
  logic [7:0] address;
  logic [7:0] data;
  logic [7:0] q;

  modport master (output MemRead, output wren, output address, output data, input q);
  modport slave  (input MemRead, input wren, input address, input data, output q);
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: RAM at 0x00..RAM_TOP plus an MMIO page (LEDs, switches, cycle counter,
// down-timer with irq). Define WATCH_EN to add the write watchpoint register at 0xF8.
module data_mem_responder #(
  parameter logic [7:0] RAM_TOP = 8'hEF,
  parameter int         SW_W    = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  input  logic [SW_W-1:0]      sw_in,
  output logic [9:0]           led_out,
  output logic                 irq,
  output logic                 watch_hit
);

  localparam logic [7:0] ADDR_LED_LO     = 8'hF0;
  localparam logic [7:0] ADDR_LED_HI     = 8'hF1;
  localparam logic [7:0] ADDR_SW         = 8'hF2;
  localparam logic [7:0] ADDR_CYC_LO     = 8'hF3;
  localparam logic [7:0] ADDR_CYC_HI     = 8'hF4;
  localparam logic [7:0] ADDR_TMR_RELOAD = 8'hF5;
  localparam logic [7:0] ADDR_TMR_CNT    = 8'hF6;
  localparam logic [7:0] ADDR_TMR_CTRL   = 8'hF7;
  localparam logic [7:0] ADDR_WATCH      = 8'hF8;

  logic [7:0]      ram [0:RAM_TOP];
  logic [7:0]      led_lo;
  logic [1:0]      led_hi;
  logic [SW_W-1:0] sw_meta, sw_sync;
  logic [15:0]     cyc_cnt;
  logic [7:0]      cyc_shadow;
  logic [7:0]      tmr_reload, tmr_cnt;
  logic            tmr_en, tmr_ar, tmr_pend;
  logic [7:0]      rd_data;
  logic            is_ram, cnt_wr, tmr_fire;

`ifdef WATCH_EN
  logic [7:0]      watch_addr;
`endif

  assign is_ram   = (bus.address <= RAM_TOP);
  assign cnt_wr   = bus.wren && (bus.address == ADDR_TMR_CNT);
  // A CPU write to the count pre-empts the expiring decrement, so no pending on that edge.
  assign tmr_fire = tmr_en && (tmr_cnt == 8'd1) && !cnt_wr;
  assign led_out  = {led_hi, led_lo};
  assign irq      = tmr_pend & tmr_en;

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    rd_data = 8'h00;
    if (is_ram) begin
      rd_data = ram[bus.address];
    end else begin
      case (bus.address)
        ADDR_LED_LO:     rd_data = led_lo;
        ADDR_LED_HI:     rd_data = {6'b0, led_hi};
        ADDR_SW:         rd_data = 8'(sw_sync);
        ADDR_CYC_LO:     rd_data = cyc_cnt[7:0];
        ADDR_CYC_HI:     rd_data = cyc_shadow;
        ADDR_TMR_RELOAD: rd_data = tmr_reload;
        ADDR_TMR_CNT:    rd_data = tmr_cnt;
        ADDR_TMR_CTRL:   rd_data = {tmr_pend, 5'b0, tmr_ar, tmr_en};
`ifdef WATCH_EN
        ADDR_WATCH:      rd_data = watch_addr;
`endif
        default:         rd_data = 8'h00;
      endcase
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; its contents survive reset.
  always_ff @(posedge clock) begin
    if (bus.wren && is_ram) ram[bus.address] <= bus.data;
  end

  // NOTE: sequential state uses non-blocking assignments, so every read here sees the pre-edge
  // value; this is what gives read-before-write on q and the pre-increment CYC_LO snapshot.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.q      <= 8'h00;
      led_lo     <= 8'h00;
      led_hi     <= 2'b00;
      sw_meta    <= '0;
      sw_sync    <= '0;
      cyc_cnt    <= 16'h0000;
      cyc_shadow <= 8'h00;
      tmr_reload <= 8'h00;
      tmr_cnt    <= 8'h00;
      tmr_en     <= 1'b0;
      tmr_ar     <= 1'b0;
      tmr_pend   <= 1'b0;
    end else begin
      if (bus.MemRead) bus.q <= rd_data;

      sw_meta <= sw_in;
      sw_sync <= sw_meta;

      // Reading the low byte latches the high byte so a 16-bit read is coherent.
      cyc_cnt <= cyc_cnt + 16'd1;
      if (bus.MemRead && bus.address == ADDR_CYC_LO) cyc_shadow <= cyc_cnt[15:8];

      if (bus.wren) begin
        case (bus.address)
          ADDR_LED_LO:     led_lo     <= bus.data;
          ADDR_LED_HI:     led_hi     <= bus.data[1:0];
          ADDR_TMR_RELOAD: tmr_reload <= bus.data;
          ADDR_TMR_CTRL: begin
            tmr_en <= bus.data[0];
            tmr_ar <= bus.data[1];
          end
          default: ;
        endcase
      end

      if (cnt_wr) begin
        tmr_cnt <= bus.data;
      end else if (tmr_en && tmr_cnt != 8'd0) begin
        tmr_cnt <= (tmr_cnt == 8'd1) ? (tmr_ar ? tmr_reload : 8'd0) : tmr_cnt - 8'd1;
      end

      // Expiry beats a simultaneous write-1-to-clear so an event is never lost.
      if (tmr_fire) begin
        tmr_pend <= 1'b1;
      end else if (bus.wren && bus.address == ADDR_TMR_CTRL && bus.data[7]) begin
        tmr_pend <= 1'b0;
      end
    end
  end

`ifdef WATCH_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      watch_addr <= 8'h00;
      watch_hit  <= 1'b0;
    end else begin
      if (bus.wren && bus.address == ADDR_WATCH) watch_addr <= bus.data;
      watch_hit <= bus.wren && is_ram && (bus.address == watch_addr);
    end
  end
`else
  assign watch_hit = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed register-map scenarios plus randomized
// bus traffic compared every cycle against a behavioural model of the memory map.
module tb_data_mem_responder;

  localparam logic [7:0] RAM_TOP = 8'hEF;
  localparam int         SW_W    = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [SW_W-1:0] sw_in = '0;
  logic [9:0]      led_out;
  logic            irq, watch_hit;

  data_mem_responder_if bus_if ();

  data_mem_responder #(.RAM_TOP(RAM_TOP), .SW_W(SW_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus_if),
    .sw_in    (sw_in),
    .led_out  (led_out),
    .irq      (irq),
    .watch_hit(watch_hit)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]      m_ram [0:255];
  logic [7:0]      m_q      = 8'h00;
  logic [9:0]      m_led    = '0;
  int unsigned     m_cyc    = 0;
  logic [7:0]      m_shadow = 8'h00;
  logic [7:0]      m_reload = 8'h00;
  logic [7:0]      m_cnt    = 8'h00;
  bit              m_en, m_ar, m_pend;
  logic [SW_W-1:0] m_sw_q[$];
  logic [7:0]      m_watch  = 8'h00;
  bit              m_hit;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a <= RAM_TOP) return m_ram[a];
    case (a)
      8'hF0: return m_led[7:0];
      8'hF1: return {6'b0, m_led[9:8]};
      8'hF2: return 8'(m_sw_q[1]);
      8'hF3: return 8'(m_cyc % 256);
      8'hF4: return m_shadow;
      8'hF5: return m_reload;
      8'hF6: return m_cnt;
      8'hF7: return {m_pend, 5'b0, m_ar, m_en};
`ifdef WATCH_EN
      8'hF8: return m_watch;
`endif
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step();
    logic       rd, wr;
    logic [7:0] a, d;
    bit         cnt_wr, fire;
    rd = bus_if.MemRead; wr = bus_if.wren; a = bus_if.address; d = bus_if.data;
    if (reset) begin
      m_q = 0; m_led = 0; m_cyc = 0; m_shadow = 0;
      m_reload = 0; m_cnt = 0; m_en = 0; m_ar = 0; m_pend = 0;
      m_watch = 0; m_hit = 0;
      m_sw_q.delete(); m_sw_q.push_back('0); m_sw_q.push_back('0);
      return;
    end
    if (rd) m_q = m_read(a);
    if (rd && a == 8'hF3) m_shadow = 8'((m_cyc / 256) % 256);
`ifdef WATCH_EN
    m_hit = wr && (a <= RAM_TOP) && (a == m_watch);
`else
    m_hit = 0;
`endif
    cnt_wr = wr && a == 8'hF6;
    fire   = m_en && m_cnt == 8'd1 && !cnt_wr;
    if (cnt_wr) m_cnt = d;
    else if (m_en && m_cnt != 0) m_cnt = (m_cnt == 1) ? (m_ar ? m_reload : 8'd0) : m_cnt - 8'd1;
    if (fire) m_pend = 1;
    else if (wr && a == 8'hF7 && d[7]) m_pend = 0;
    if (wr) begin
      if (a <= RAM_TOP) m_ram[a] = d;
      if (a == 8'hF0) m_led[7:0] = d;
      if (a == 8'hF1) m_led[9:8] = d[1:0];
      if (a == 8'hF5) m_reload = d;
      if (a == 8'hF7) begin m_en = d[0]; m_ar = d[1]; end
      if (a == 8'hF8) m_watch = d;
    end
    m_cyc = (m_cyc + 1) % 65536;
    m_sw_q.push_front(sw_in);
    void'(m_sw_q.pop_back());
  endtask

  always @(posedge clock) model_step();

  always @(negedge clock) begin
    if (chk_en) begin
      check("q", {8'h00, bus_if.q}, {8'h00, m_q});
      check("led_out", {6'h00, led_out}, {6'h00, m_led});
      check("irq", {15'h0, irq}, {15'h0, m_pend & m_en});
      check("watch_hit", {15'h0, watch_hit}, {15'h0, m_hit});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    bus_if.MemRead = rd; bus_if.wren = wr; bus_if.address = a; bus_if.data = d;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  initial begin
    bus_if.MemRead = 0; bus_if.wren = 0; bus_if.address = 0; bus_if.data = 0;
    @(negedge clock);
    do_reset();
    chk_en = 1'b1;
    check("reset q", {8'h00, bus_if.q}, 16'h0000);
    check("reset led", {6'h00, led_out}, 16'h0000);
    check("reset irq", {15'h0, irq}, 16'h0000);

    for (int i = 0; i <= RAM_TOP; i++) cycle(1'b0, 1'b1, 8'(i), 8'($urandom));

    // RAM and read-before-write
    cycle(0, 1, 8'h10, 8'h5A);
    cycle(1, 0, 8'h10, 8'h00); check("ram read", {8'h00, bus_if.q}, 16'h005A);
    cycle(1, 1, 8'h10, 8'hA5); check("rbw old", {8'h00, bus_if.q}, 16'h005A);
    cycle(1, 0, 8'h10, 8'h00); check("rbw new", {8'h00, bus_if.q}, 16'h00A5);

    // LEDs and reset retention of RAM
    cycle(0, 1, 8'hF0, 8'h3C);
    cycle(0, 1, 8'hF1, 8'hFF); check("led value", {6'h00, led_out}, 16'h033C);
    cycle(1, 0, 8'hF1, 8'h00); check("led_hi read", {8'h00, bus_if.q}, 16'h0003);
    do_reset();                check("led after reset", {6'h00, led_out}, 16'h0000);
    cycle(1, 0, 8'h10, 8'h00); check("ram kept", {8'h00, bus_if.q}, 16'h00A5);

    // Switch synchronizer and RO write
    sw_in = 5'b10101;
    cycle(1, 0, 8'hF2, 8'h00); check("sw edge1", {8'h00, bus_if.q}, 16'h0000);
    cycle(1, 0, 8'hF2, 8'h00); check("sw edge2", {8'h00, bus_if.q}, 16'h0000);
    cycle(1, 0, 8'hF2, 8'h00); check("sw synced", {8'h00, bus_if.q}, 16'h0015);
    cycle(0, 1, 8'hF2, 8'hFF);
    cycle(1, 0, 8'hF2, 8'h00); check("sw ro", {8'h00, bus_if.q}, 16'h0015);

    // Timer: reload 3, autoreload
    cycle(0, 1, 8'hF5, 8'h03);
    cycle(0, 1, 8'hF6, 8'h03);
    cycle(0, 1, 8'hF7, 8'h03);
    idle(); idle();            check("tmr not yet", {15'h0, irq}, 16'h0000);
    idle();                    check("tmr fire", {15'h0, irq}, 16'h0001);
    cycle(1, 0, 8'hF6, 8'h00); check("tmr reloaded", {8'h00, bus_if.q}, 16'h0003);
    cycle(0, 1, 8'hF7, 8'h83); check("tmr w1c", {15'h0, irq}, 16'h0000);
    idle();                    check("tmr refire", {15'h0, irq}, 16'h0001);
    idle(); idle();
    cycle(0, 1, 8'hF7, 8'h83); check("tmr set beats w1c", {15'h0, irq}, 16'h0001);
    cycle(0, 1, 8'hF7, 8'h83); check("tmr w1c again", {15'h0, irq}, 16'h0000);
    idle();
    cycle(0, 1, 8'hF6, 8'h05); check("tmr cnt write wins", {15'h0, irq}, 16'h0000);
    cycle(1, 0, 8'hF6, 8'h00); check("tmr cnt value", {8'h00, bus_if.q}, 16'h0005);
    cycle(0, 1, 8'hF7, 8'h80);

    // Watchpoint
`ifdef WATCH_EN
    cycle(0, 1, 8'hF8, 8'h20);
    cycle(0, 1, 8'h20, 8'h77); check("watch hit", {15'h0, watch_hit}, 16'h0001);
    idle();                    check("watch one cycle", {15'h0, watch_hit}, 16'h0000);
    cycle(0, 1, 8'hF8, 8'hF0);
    cycle(0, 1, 8'hF0, 8'h11); check("watch mmio", {15'h0, watch_hit}, 16'h0000);
    cycle(1, 0, 8'hF8, 8'h00); check("watch read", {8'h00, bus_if.q}, 16'h00F0);
`else
    cycle(0, 1, 8'hF8, 8'h20);
    cycle(1, 0, 8'hF8, 8'h00); check("watch absent read", {8'h00, bus_if.q}, 16'h0000);
    cycle(0, 1, 8'h20, 8'h77); check("watch absent", {15'h0, watch_hit}, 16'h0000);
`endif

    // Cycle counter: snapshot, shadow, wrap
    do_reset();
    repeat (299) idle();
    cycle(1, 0, 8'hF3, 8'h00); check("cyc lo 012B", {8'h00, bus_if.q}, 16'h002B);
    repeat (7) idle();
    cycle(1, 0, 8'hF4, 8'h00); check("cyc hi 012B", {8'h00, bus_if.q}, 16'h0001);
    do_reset();
    repeat (65535) idle();
    cycle(1, 0, 8'hF3, 8'h00); check("cyc lo FFFF", {8'h00, bus_if.q}, 16'h00FF);
    cycle(1, 0, 8'hF4, 8'h00); check("cyc hi FFFF", {8'h00, bus_if.q}, 16'h00FF);
    cycle(1, 0, 8'hF3, 8'h00); check("cyc lo wrapped", {8'h00, bus_if.q}, 16'h0001);
    cycle(1, 0, 8'hF4, 8'h00); check("cyc hi wrapped", {8'h00, bus_if.q}, 16'h0000);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] a, d;
      bit rd, wr;
      if ($urandom_range(0, 9) == 0) sw_in = SW_W'($urandom);
      a  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, RAM_TOP)) : 8'($urandom_range(8'hF0, 8'hFF));
      d  = 8'($urandom);
      if ((a == 8'hF5 || a == 8'hF6) && $urandom_range(0, 1) == 0) d = 8'($urandom_range(0, 6));
      rd = 1'($urandom);
      wr = 1'($urandom);
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle(rd, wr, a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
